// File: rtl/devil_snoop_ctrl.sv
// ACE snoop responder: accepts AC beats, filters them by snoop type and address
// windows, and answers on CR either immediately or after a programmable delay.
module devil_snoop_ctrl #(
   parameter int ADDR_W = 44,
   parameter int NWIN   = 4,
   parameter int DLY_W  = 16
) (
   input  logic                     clk_100MHz,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     func,
   input  logic                     acflt_en,
   input  logic [3:0]               acsnoop_match,
   input  logic                     addrflt_en,
   input  logic [NWIN-1:0]          win_en,
   input  logic [NWIN*ADDR_W-1:0]   win_base,
   input  logic [NWIN*ADDR_W-1:0]   win_size,
   input  logic [DLY_W-1:0]         delay,
   input  logic [4:0]               crresp_cfg,
   input  logic                     acvalid,
   output logic                     acready,
   input  logic [ADDR_W-1:0]        acaddr,
   input  logic [3:0]               acsnoop,
   output logic                     crvalid,
   input  logic                     crready,
   output logic [4:0]               crresp,
   output logic                     done,
   input  logic                     done_clr,
   output logic [15:0]              hit_cnt,
   output logic [2:0]               hit_win
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t            state_r, next_state_s;
   logic              acready_r, crvalid_r, acready_nxt_s, crvalid_nxt_s;
   logic [4:0]        crresp_r;
   logic [DLY_W-1:0]  cnt_r;
   logic              done_r, hit_pend_r, osh_r;
   logic [15:0]       hit_cnt_r;
   logic [2:0]        hit_win_r, win_idx_s;
   logic [NWIN-1:0]   win_hit_s;
   logic              accept_s, hit_s, cr_hs_s, inc_s, done_set_s;

   // Window limit is formed one bit wider so base+size never wraps.
   function automatic logic win_match(input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] size,
                                      input logic [ADDR_W-1:0] addr);
      logic [ADDR_W:0] lim;
      lim = {1'b0, base} + {1'b0, size};
      return (addr >= base) && ({1'b0, addr} < lim);
   endfunction

   assign accept_s   = acvalid && acready_r;
   assign cr_hs_s    = crvalid_r && crready;
   assign inc_s      = accept_s && hit_s;
   assign done_set_s = cr_hs_s && hit_pend_r && osh_r;

   // Per-window match and lowest-index priority select.
   always_comb begin
      win_idx_s = 3'd0;
      for (int i = NWIN - 1; i >= 0; i--) begin
         win_hit_s[i] = win_en[i] && win_match(win_base[i*ADDR_W +: ADDR_W],
                                               win_size[i*ADDR_W +: ADDR_W], acaddr);
         win_idx_s    = win_hit_s[i] ? 3'(i) : win_idx_s;
      end
   end

   assign hit_s = en && !done_r && (!acflt_en || (acsnoop == acsnoop_match))
                  && (!addrflt_en || (|win_hit_s));

   // State register.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = (hit_s && (delay != '0)) ? ST_DELAY : ST_RESP;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_DELAY: begin
            if (cnt_r <= DLY_W'(1)) begin
               next_state_s = ST_RESP;
            end else begin
               next_state_s = ST_DELAY;
            end
         end
         ST_RESP: begin
            if (cr_hs_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_RESP;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so handshake outputs are registered.
   always_comb begin
      acready_nxt_s = 1'b0;
      crvalid_nxt_s = 1'b0;
      case (next_state_s)
         ST_IDLE:  acready_nxt_s = 1'b1;
         ST_RESP:  crvalid_nxt_s = 1'b1;
         default: begin
            acready_nxt_s = 1'b0;
            crvalid_nxt_s = 1'b0;
         end
      endcase
   end

   // Handshake output registers.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         acready_r <= 1'b0;
         crvalid_r <= 1'b0;
      end else begin
         acready_r <= acready_nxt_s;
         crvalid_r <= crvalid_nxt_s;
      end
   end

   // Per-snoop context captured at acceptance; delay counter.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         crresp_r   <= 5'd0;
         cnt_r      <= '0;
         hit_pend_r <= 1'b0;
         osh_r      <= 1'b0;
      end else if (accept_s) begin
         crresp_r   <= hit_s ? crresp_cfg : 5'd0;
         cnt_r      <= hit_s ? delay : '0;
         hit_pend_r <= hit_s;
         osh_r      <= !func;
      end else if (state_r == ST_DELAY) begin
         cnt_r      <= cnt_r - DLY_W'(1);
      end else if (cr_hs_s) begin
         crresp_r   <= 5'd0;
         hit_pend_r <= 1'b0;
      end
   end

   // Status: one-shot flag, saturating hit counter, last hit window.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         done_r    <= 1'b0;
         hit_cnt_r <= 16'd0;
         hit_win_r <= 3'd0;
      end else begin
         if (done_set_s) begin
            done_r <= 1'b1;
         end else if (done_clr) begin
            done_r <= 1'b0;
         end
         if (inc_s) begin
            hit_cnt_r <= (hit_cnt_r == 16'hFFFF) ? hit_cnt_r : hit_cnt_r + 16'd1;
            hit_win_r <= addrflt_en ? win_idx_s : 3'd0;
         end else if (done_clr) begin
            hit_cnt_r <= 16'd0;
         end
      end
   end

   assign acready = acready_r;
   assign crvalid = crvalid_r;
   assign crresp  = crresp_r;
   assign done    = done_r;
   assign hit_cnt = hit_cnt_r;
   assign hit_win = hit_win_r;

endmodule

// File: tb/tb_devil_snoop_ctrl.sv
// Directed bench for devil_snoop_ctrl: latency, response value, filters, one-shot and reset.
module tb_devil_snoop_ctrl;

   localparam int ADDR_W = 44;
   localparam int NWIN   = 4;
   localparam int DLY_W  = 16;

   logic                   tb_clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   en = 1'b0, func = 1'b0, acflt_en = 1'b0, addrflt_en = 1'b0;
   logic [3:0]             acsnoop_match = 4'd0;
   logic [NWIN-1:0]        win_en = '0;
   logic [NWIN*ADDR_W-1:0] win_base = '0, win_size = '0;
   logic [DLY_W-1:0]       delay = '0;
   logic [4:0]             crresp_cfg = 5'd0;
   logic                   acvalid = 1'b0, crready = 1'b0, done_clr = 1'b0;
   logic [ADDR_W-1:0]      acaddr = '0;
   logic [3:0]             acsnoop = 4'd0;
   logic                   acready, crvalid, done;
   logic [4:0]             crresp;
   logic [15:0]            hit_cnt;
   logic [2:0]             hit_win;

   int checks = 0;
   int failures = 0;
   int lat;
   logic [4:0] resp;

   always #5 tb_clk = ~tb_clk;

   devil_snoop_ctrl #(.ADDR_W(ADDR_W), .NWIN(NWIN), .DLY_W(DLY_W)) dut (
      .clk_100MHz(tb_clk), .reset(reset), .en(en), .func(func),
      .acflt_en(acflt_en), .acsnoop_match(acsnoop_match),
      .addrflt_en(addrflt_en), .win_en(win_en), .win_base(win_base), .win_size(win_size),
      .delay(delay), .crresp_cfg(crresp_cfg),
      .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop),
      .crvalid(crvalid), .crready(crready), .crresp(crresp),
      .done(done), .done_clr(done_clr), .hit_cnt(hit_cnt), .hit_win(hit_win)
   );

   // Present one AC beat and return just after the accepting edge.
   task automatic start_snoop(input logic [ADDR_W-1:0] addr, input logic [3:0] typ);
      int g = 0;
      while (!acready && g < 50) begin
         @(negedge tb_clk);
         g++;
      end
      acaddr  = addr;
      acsnoop = typ;
      acvalid = 1'b1;
      @(posedge tb_clk);
      #1 acvalid = 1'b0;
   endtask

   // Count falling edges until crvalid is seen; -1 on timeout.
   task automatic wait_cr(output int l, output logic [4:0] r);
      l = 0;
      do begin
         @(negedge tb_clk);
         l++;
      end while (!crvalid && l < 300);
      if (!crvalid) l = -1;
      r = crresp;
   endtask

   task automatic cr_handshake();
      crready = 1'b1;
      @(posedge tb_clk);
      #1 crready = 1'b0;
      @(negedge tb_clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge tb_clk);
      checks++; if (acready !== 1'b0) begin failures++; $display("FAIL reset_acready got=%0b exp=0", acready); end
      checks++; if (crvalid !== 1'b0) begin failures++; $display("FAIL reset_crvalid got=%0b exp=0", crvalid); end
      checks++; if (crresp !== 5'd0) begin failures++; $display("FAIL reset_crresp got=%0h exp=0", crresp); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++; if (hit_cnt !== 16'd0) begin failures++; $display("FAIL reset_hit_cnt got=%0d exp=0", hit_cnt); end
      checks++; if (hit_win !== 3'd0) begin failures++; $display("FAIL reset_hit_win got=%0d exp=0", hit_win); end
      reset = 1'b0;
      @(negedge tb_clk);
      checks++; if (acready !== 1'b1) begin failures++; $display("FAIL reset_release_acready got=%0b exp=1", acready); end
   endtask

   task automatic test_disabled();
      en = 1'b0;
      start_snoop(44'h40, 4'd0);
      wait_cr(lat, resp);
      checks++; if (lat !== 1) begin failures++; $display("FAIL dis_latency got=%0d exp=1", lat); end
      checks++; if (resp !== 5'd0) begin failures++; $display("FAIL dis_crresp got=%0h exp=0", resp); end
      cr_handshake();
      checks++; if (acready !== 1'b1) begin failures++; $display("FAIL dis_acready_after got=%0b exp=1", acready); end
      checks++; if (hit_cnt !== 16'd0) begin failures++; $display("FAIL dis_hit_cnt got=%0d exp=0", hit_cnt); end
   endtask

   task automatic test_con_delay();
      en = 1'b1; func = 1'b1; delay = 16'd2; crresp_cfg = 5'h1F;
      for (int k = 0; k < 3; k++) begin
         start_snoop(44'h100 + 44'(k), 4'd2);
         wait_cr(lat, resp);
         checks++; if (lat !== 3) begin failures++; $display("FAIL con_latency[%0d] got=%0d exp=3", k, lat); end
         checks++; if (resp !== 5'h1F) begin failures++; $display("FAIL con_crresp[%0d] got=%0h exp=1f", k, resp); end
         cr_handshake();
      end
      checks++; if (hit_cnt !== 16'd3) begin failures++; $display("FAIL con_hit_cnt got=%0d exp=3", hit_cnt); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL con_done got=%0b exp=0", done); end
   endtask

   task automatic test_osh();
      func = 1'b0; delay = 16'd0; crresp_cfg = 5'h0A;
      start_snoop(44'h200, 4'd1);
      wait_cr(lat, resp);
      checks++; if (lat !== 1) begin failures++; $display("FAIL osh_latency got=%0d exp=1", lat); end
      checks++; if (resp !== 5'h0A) begin failures++; $display("FAIL osh_crresp1 got=%0h exp=0a", resp); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL osh_done_early got=%0b exp=0", done); end
      cr_handshake();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL osh_done got=%0b exp=1", done); end
      start_snoop(44'h204, 4'd1);
      wait_cr(lat, resp);
      checks++; if (resp !== 5'd0) begin failures++; $display("FAIL osh_crresp2 got=%0h exp=0", resp); end
      cr_handshake();
      checks++; if (hit_cnt !== 16'd4) begin failures++; $display("FAIL osh_hit_cnt got=%0d exp=4", hit_cnt); end
      done_clr = 1'b1;
      @(posedge tb_clk);
      #1 done_clr = 1'b0;
      @(negedge tb_clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL osh_clr_done got=%0b exp=0", done); end
      checks++; if (hit_cnt !== 16'd0) begin failures++; $display("FAIL osh_clr_hit_cnt got=%0d exp=0", hit_cnt); end
   endtask

   task automatic test_addr_win();
      logic [ADDR_W-1:0] addrs [4];
      logic [4:0]        exp_r [4];
      addrs = '{44'h0F, 44'h10, 44'h10F, 44'h110};
      exp_r = '{5'd0, 5'h03, 5'h03, 5'd0};
      func = 1'b1; delay = 16'd0; crresp_cfg = 5'h03; addrflt_en = 1'b1;
      win_en = 4'b0011;
      win_base[0*ADDR_W +: ADDR_W] = 44'h10;
      win_size[0*ADDR_W +: ADDR_W] = 44'h0;
      win_base[1*ADDR_W +: ADDR_W] = 44'h10;
      win_size[1*ADDR_W +: ADDR_W] = 44'h100;
      for (int k = 0; k < 4; k++) begin
         start_snoop(addrs[k], 4'd0);
         wait_cr(lat, resp);
         checks++; if (resp !== exp_r[k]) begin failures++; $display("FAIL win_crresp addr=%0h got=%0h exp=%0h", addrs[k], resp, exp_r[k]); end
         cr_handshake();
      end
      checks++; if (hit_cnt !== 16'd2) begin failures++; $display("FAIL win_hit_cnt got=%0d exp=2", hit_cnt); end
      checks++; if (hit_win !== 3'd1) begin failures++; $display("FAIL win_hit_win got=%0d exp=1", hit_win); end
   endtask

   task automatic test_type_stall();
      addrflt_en = 1'b0; acflt_en = 1'b1; acsnoop_match = 4'd1;
      delay = 16'd3; crresp_cfg = 5'h15;
      start_snoop(44'h300, 4'd0);
      wait_cr(lat, resp);
      checks++; if (lat !== 1) begin failures++; $display("FAIL type0_latency got=%0d exp=1", lat); end
      checks++; if (resp !== 5'd0) begin failures++; $display("FAIL type0_crresp got=%0h exp=0", resp); end
      cr_handshake();
      start_snoop(44'h304, 4'd1);
      wait_cr(lat, resp);
      checks++; if (lat !== 4) begin failures++; $display("FAIL type1_latency got=%0d exp=4", lat); end
      for (int k = 0; k < 5; k++) begin
         @(negedge tb_clk);
         checks++; if (crvalid !== 1'b1 || crresp !== 5'h15) begin failures++; $display("FAIL stall_hold[%0d] crvalid=%0b crresp=%0h exp 1/15", k, crvalid, crresp); end
      end
      cr_handshake();
      checks++; if (hit_cnt !== 16'd3) begin failures++; $display("FAIL type_hit_cnt got=%0d exp=3", hit_cnt); end
      checks++; if (hit_win !== 3'd0) begin failures++; $display("FAIL type_hit_win got=%0d exp=0", hit_win); end
   endtask

   task automatic test_back_to_back();
      acflt_en = 1'b0; delay = 16'd2; crresp_cfg = 5'h11;
      start_snoop(44'h400, 4'd7);
      delay = 16'd50; crresp_cfg = 5'h00; en = 1'b0;
      wait_cr(lat, resp);
      checks++; if (lat !== 3) begin failures++; $display("FAIL inflight_latency got=%0d exp=3", lat); end
      checks++; if (resp !== 5'h11) begin failures++; $display("FAIL inflight_crresp got=%0h exp=11", resp); end
      cr_handshake();
      start_snoop(44'h404, 4'd7);
      wait_cr(lat, resp);
      checks++; if (lat !== 1) begin failures++; $display("FAIL en_off_latency got=%0d exp=1", lat); end
      checks++; if (resp !== 5'd0) begin failures++; $display("FAIL en_off_crresp got=%0h exp=0", resp); end
      cr_handshake();
      checks++; if (hit_cnt !== 16'd4) begin failures++; $display("FAIL b2b_hit_cnt got=%0d exp=4", hit_cnt); end
   endtask

   task automatic test_reset_mid();
      en = 1'b1; delay = 16'd100; crresp_cfg = 5'h07;
      start_snoop(44'h500, 4'd0);
      repeat (3) @(negedge tb_clk);
      reset = 1'b1;
      #1;
      checks++; if (crvalid !== 1'b0) begin failures++; $display("FAIL rmid_crvalid got=%0b exp=0", crvalid); end
      checks++; if (acready !== 1'b0) begin failures++; $display("FAIL rmid_acready got=%0b exp=0", acready); end
      checks++; if (hit_cnt !== 16'd0) begin failures++; $display("FAIL rmid_hit_cnt got=%0d exp=0", hit_cnt); end
      repeat (2) @(negedge tb_clk);
      reset = 1'b0;
      @(negedge tb_clk);
      checks++; if (acready !== 1'b1) begin failures++; $display("FAIL rmid_release_acready got=%0b exp=1", acready); end
      delay = 16'd1;
      start_snoop(44'h504, 4'd0);
      wait_cr(lat, resp);
      checks++; if (lat !== 2) begin failures++; $display("FAIL rmid_latency got=%0d exp=2", lat); end
      checks++; if (resp !== 5'h07) begin failures++; $display("FAIL rmid_crresp got=%0h exp=07", resp); end
      cr_handshake();
      checks++; if (hit_cnt !== 16'd1) begin failures++; $display("FAIL rmid_hit_cnt_after got=%0d exp=1", hit_cnt); end
   endtask

   initial begin
      test_reset();
      test_disabled();
      test_con_delay();
      test_osh();
      test_addr_win();
      test_type_stall();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
